// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction is outstanding at a time: a request is accepted in IDLE,
// its fields are registered and presented downstream in REQ until the memory
// accepts them, and the response is awaited in WAIT. The response is returned
// to the owner as a one-cycle pulse in the cycle the FSM is back in IDLE.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin between IF and LS on contention
//              undefined -> fixed priority, LS wins on contention
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req_*                 fetch request (valid/addr) and ready
//   if_resp_valid/inst       fetched instruction, one-cycle pulse
//   ls_req_*                 load/store request (valid/wen/addr/wdata/wmask)
//   ls_req_ready             load/store request accepted
//   ls_resp_valid/rdata      load data or store completion, one-cycle pulse
//   flush                    pipeline redirect, kills IF traffic only
//   mem_req_*                registered downstream request
//   mem_resp_valid/rdata     downstream response
//   busy                     a transaction is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [31:0]           if_resp_inst,

    input  logic                  ls_req_valid,
    input  logic                  ls_req_wen,
    input  logic [ADDR_W-1:0]     ls_req_addr,
    input  logic [DATA_W-1:0]     ls_req_wdata,
    input  logic [DATA_W/8-1:0]   ls_req_wmask,
    output logic                  ls_req_ready,
    output logic                  ls_resp_valid,
    output logic [DATA_W-1:0]     ls_resp_rdata,

    input  logic                  flush,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_rdata,

    output logic                  busy
);

    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    state_t              state_q,         state_d;
    owner_t              owner_q,         owner_d;
    logic                drop_q,          drop_d;
    logic                sel_hi_q,        sel_hi_d;
    logic                req_wen_q,       req_wen_d;
    logic [ADDR_W-1:0]   req_addr_q,      req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q,     req_wdata_d;
    logic [MASK_W-1:0]   req_wmask_q,     req_wmask_d;
    logic                if_resp_valid_q, if_resp_valid_d;
    logic [31:0]         if_resp_inst_q,  if_resp_inst_d;
    logic                ls_resp_valid_q, ls_resp_valid_d;
    logic [DATA_W-1:0]   ls_resp_rdata_q, ls_resp_rdata_d;

    logic                idle;
    logic                if_cand;
    logic                ls_pri;
    logic                grant_if;
    logic                grant_ls;

`ifdef ARB_RR_EN
    owner_t              last_owner_q,    last_owner_d;
`endif

    // -------------------------------------------------------------------------
    // Grant logic (combinational from state, valids and flush)
    // -------------------------------------------------------------------------
    // Readies are also masked while reset is asserted so that every output
    // reads 0 during reset, not only after the next edge.
    assign idle    = (state_q == S_IDLE) && !rst;
    // A fetch presented together with a flush is for a dead path: it neither
    // gets accepted nor competes with LS.
    assign if_cand = if_req_valid && !flush;

`ifdef ARB_RR_EN
    assign ls_pri  = (last_owner_q == OWN_IF);
`else
    assign ls_pri  = 1'b1;
`endif

    assign grant_ls = idle && ls_req_valid && (!if_cand || ls_pri);
    assign grant_if = idle && if_cand && !grant_ls;

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        drop_d          = drop_q;
        sel_hi_d        = sel_hi_q;
        req_wen_d       = req_wen_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        req_wmask_d     = req_wmask_q;
        if_resp_valid_d = 1'b0;
        if_resp_inst_d  = if_resp_inst_q;
        ls_resp_valid_d = 1'b0;
        ls_resp_rdata_d = ls_resp_rdata_q;
`ifdef ARB_RR_EN
        last_owner_d    = last_owner_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (grant_ls) begin
                    state_d     = S_REQ;
                    owner_d     = OWN_LS;
                    req_wen_d   = ls_req_wen;
                    req_addr_d  = ls_req_addr;
                    req_wdata_d = ls_req_wdata;
                    req_wmask_d = ls_req_wmask;
`ifdef ARB_RR_EN
                    last_owner_d = OWN_LS;
`endif
                end else if (grant_if) begin
                    state_d     = S_REQ;
                    owner_d     = OWN_IF;
                    sel_hi_d    = if_req_addr[2];
                    req_wen_d   = 1'b0;
                    req_addr_d  = {if_req_addr[ADDR_W-1:3], 3'b000};
                    req_wdata_d = '0;
                    req_wmask_d = '0;
`ifdef ARB_RR_EN
                    last_owner_d = OWN_IF;
`endif
                end
            end

            S_REQ: begin
                if (flush && owner_q == OWN_IF) begin
                    drop_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (flush && owner_q == OWN_IF) begin
                    drop_d = 1'b1;
                end
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    if (owner_q == OWN_LS) begin
                        ls_resp_valid_d = 1'b1;
                        ls_resp_rdata_d = req_wen_q ? '0 : mem_resp_rdata;
                    end else if (!(drop_q || flush)) begin
                        // A flush arriving together with the response still
                        // kills it; the held instruction is left untouched.
                        if_resp_valid_d = 1'b1;
                        if_resp_inst_d  = sel_hi_q ? mem_resp_rdata[63:32]
                                                   : mem_resp_rdata[31:0];
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            owner_q         <= OWN_IF;
            drop_q          <= 1'b0;
            sel_hi_q        <= 1'b0;
            req_wen_q       <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_wmask_q     <= '0;
            if_resp_valid_q <= 1'b0;
            if_resp_inst_q  <= '0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_rdata_q <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            drop_q          <= drop_d;
            sel_hi_q        <= sel_hi_d;
            req_wen_q       <= req_wen_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            req_wmask_q     <= req_wmask_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_inst_q  <= if_resp_inst_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            ls_resp_rdata_q <= ls_resp_rdata_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_wen   = req_wen_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;

    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_inst  = if_resp_inst_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_resp_rdata = ls_resp_rdata_q;

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives whole transactions through the arbiter (directed cases followed by a
// randomized run) and checks every observable against values computed from the
// arbitration, alignment, selection and flush rules.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_inst;
    logic        ls_req_valid;
    logic        ls_req_wen;
    logic [63:0] ls_req_addr;
    logic [63:0] ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_req_ready;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_rdata;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: who won the last accept, and the last delivered data.
    bit          last_ls;
    logic [31:0] exp_inst;
    logic [63:0] exp_ls;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_addr    (if_req_addr),
        .if_req_ready   (if_req_ready),
        .if_resp_valid  (if_resp_valid),
        .if_resp_inst   (if_resp_inst),
        .ls_req_valid   (ls_req_valid),
        .ls_req_wen     (ls_req_wen),
        .ls_req_addr    (ls_req_addr),
        .ls_req_wdata   (ls_req_wdata),
        .ls_req_wmask   (ls_req_wmask),
        .ls_req_ready   (ls_req_ready),
        .ls_resp_valid  (ls_resp_valid),
        .ls_resp_rdata  (ls_resp_rdata),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input string tag, input logic [63:0] a, input logic w,
                           input logic [63:0] d, input logic [7:0] m);
        chk({tag, "_addr"},  mem_req_addr,  a);
        chk({tag, "_wen"},   mem_req_wen,   w);
        chk({tag, "_wdata"}, mem_req_wdata, d);
        chk({tag, "_wmask"}, mem_req_wmask, m);
    endtask

    // One complete transaction.
    //   fmode: 0 no flush, 1 flush pulse in first REQ cycle, 2 in first WAIT cycle
    task automatic txn(input bit use_if, input bit contend, input bit st,
                       input logic [63:0] ia, input logic [63:0] la,
                       input logic [63:0] wd, input logic [7:0] wm,
                       input logic [63:0] rd, input int unsigned rwait,
                       input int unsigned swait, input int unsigned fmode);
        bit          own_if;
        bit          drop;
        logic [63:0] ea;
        logic [63:0] ed;
        logic [7:0]  em;
        logic        ew;

`ifdef ARB_RR_EN
        own_if = contend ? last_ls : use_if;
`else
        own_if = contend ? 1'b0 : use_if;
`endif
        ea = own_if ? (ia & ~64'h7) : la;
        ew = own_if ? 1'b0 : st;
        ed = own_if ? 64'h0 : wd;
        em = own_if ? 8'h00 : wm;
        drop = own_if && (fmode != 0);

        // Accept cycle
        if_req_valid = contend || use_if;
        if_req_addr  = ia;
        ls_req_valid = contend || !use_if;
        ls_req_wen   = st;
        ls_req_addr  = la;
        ls_req_wdata = wd;
        ls_req_wmask = wm;
        #1;
        chk("if_ready", if_req_ready, own_if);
        chk("ls_ready", ls_req_ready, !own_if);
        tick;
        last_ls      = !own_if;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;

        // First REQ cycle
        chk("req_valid", mem_req_valid, 1'b1);
        chk("req_busy", busy, 1'b1);
        chk("pulse_if_clr", if_resp_valid, 1'b0);
        chk("pulse_ls_clr", ls_resp_valid, 1'b0);
        chk("inst_held", if_resp_inst, exp_inst);
        chk("rdata_held", ls_resp_rdata, exp_ls);
        chk_mem("req", ea, ew, ed, em);
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        chk("if_ready_busy", if_req_ready, 1'b0);
        chk("ls_ready_busy", ls_req_ready, 1'b0);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        flush = (fmode == 1);

        // Backpressure, with stray responses that must be ignored
        for (int i = 0; i < int'(rwait); i++) begin
            mem_resp_valid = 1'($urandom);
            mem_resp_rdata = {$urandom, $urandom};
            tick;
            flush = 1'b0;
            mem_resp_valid = 1'b0;
            chk("stall_valid", mem_req_valid, 1'b1);
            chk("stall_busy", busy, 1'b1);
            chk_mem("stall", ea, ew, ed, em);
        end
        mem_req_ready = 1'b1;
        tick;
        flush = 1'b0;
        mem_req_ready = 1'b0;

        // WAIT
        chk("wait_valid", mem_req_valid, 1'b0);
        chk("wait_busy", busy, 1'b1);
        flush = (fmode == 2);
        for (int i = 0; i < int'(swait); i++) begin
            tick;
            flush = 1'b0;
            chk("wait_busy2", busy, 1'b1);
            chk("wait_if_v", if_resp_valid, 1'b0);
            chk("wait_ls_v", ls_resp_valid, 1'b0);
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        tick;
        flush = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = {$urandom, $urandom};

        // Response cycle: back in IDLE
        if (own_if && !drop) exp_inst = ia[2] ? rd[63:32] : rd[31:0];
        if (!own_if) exp_ls = st ? 64'h0 : rd;
        chk("resp_if_v", if_resp_valid, own_if && !drop);
        chk("resp_ls_v", ls_resp_valid, !own_if);
        chk("resp_inst", if_resp_inst, exp_inst);
        chk("resp_rdata", ls_resp_rdata, exp_ls);
        chk("resp_busy", busy, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        if_req_valid   = 1'b0;
        if_req_addr    = '0;
        ls_req_valid   = 1'b0;
        ls_req_wen     = 1'b0;
        ls_req_addr    = '0;
        ls_req_wdata   = '0;
        ls_req_wmask   = '0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        last_ls        = 1'b0;
        exp_inst       = '0;
        exp_ls         = '0;

        // Reset state
        tick;
        tick;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_if_v", if_resp_valid, 1'b0);
        chk("rst_ls_v", ls_resp_valid, 1'b0);
        chk_mem("rst", 64'h0, 1'b0, 64'h0, 8'h00);
        rst = 1'b0;
        tick;

        // Single fetch from the upper word
        txn(1, 0, 0, 64'h8000_0004, 64'h0, 64'h0, 8'h0,
            64'h00100073_00000013, 0, 0, 0);
        chk("tp_inst", if_resp_inst, 64'h0010_0073);

        // Contention twice (LS first; second depends on arbitration mode)
        txn(1, 1, 0, 64'h8000_0100, 64'h8000_1000, 64'h0, 8'h0,
            64'hDEAD_BEEF_0BAD_F00D, 0, 1, 0);
        txn(1, 1, 0, 64'h8000_0108, 64'h8000_1008, 64'h0, 8'h0,
            64'h0123_4567_89AB_CDEF, 0, 0, 0);

        // Store: fields passed through exactly, completion data 0
        txn(0, 0, 1, 64'h0, 64'h8000_2000, 64'h1122_3344_5566_7788, 8'h0F,
            64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);

        // Flush while the fetch waits in WAIT, then a normal fetch
        txn(1, 0, 0, 64'h8000_0200, 64'h0, 64'h0, 8'h0,
            64'hAAAA_AAAA_5555_5555, 0, 2, 2);
        txn(1, 0, 0, 64'h8000_0204, 64'h0, 64'h0, 8'h0,
            64'h1357_9BDF_2468_ACE0, 0, 0, 0);

        // Flush during an LS transaction has no effect
        txn(0, 0, 0, 64'h0, 64'h8000_3008, 64'h0, 8'h0,
            64'h7777_6666_5555_4444, 1, 1, 1);

        // Backpressure for 5 cycles
        txn(1, 0, 0, 64'h8000_0300, 64'h0, 64'h0, 8'h0,
            64'hCAFE_0001_CAFE_0002, 5, 0, 0);

        // Flush in IDLE blocks IF only
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0400;
        flush        = 1'b1;
        #1;
        chk("idle_flush_if", if_req_ready, 1'b0);
        chk("idle_flush_ls", ls_req_ready, 1'b0);
        tick;
        if_req_valid = 1'b0;
        flush        = 1'b0;
        chk("idle_flush_busy", busy, 1'b0);

        // Reset while a fetch waits for its response
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0508;
        #1;
        tick;
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        chk("mid_busy", busy, 1'b1);
        rst          = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_req_valid", mem_req_valid, 1'b0);
        chk("mrst_if_ready", if_req_ready, 1'b0);
        chk("mrst_ls_ready", ls_req_ready, 1'b0);
        chk("mrst_inst", if_resp_inst, 64'h0);
        chk("mrst_rdata", ls_resp_rdata, 64'h0);
        chk_mem("mrst", 64'h0, 1'b0, 64'h0, 8'h00);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        last_ls  = 1'b0;
        exp_inst = '0;
        exp_ls   = '0;
        tick;
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h1234_5678_9ABC_DEF0;
        tick;
        mem_resp_valid = 1'b0;
        chk("late_busy", busy, 1'b0);
        tick;
        chk("late_if_v", if_resp_valid, 1'b0);
        chk("late_ls_v", ls_resp_valid, 1'b0);
        chk("late_inst", if_resp_inst, 64'h0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            bit          u_if;
            bit          cont;
            bit          st;
            logic [63:0] ia;
            logic [63:0] la;
            logic [63:0] wd;
            logic [63:0] rd;
            int unsigned fm;
            u_if = 1'($urandom);
            cont = ($urandom_range(0, 3) == 0);
            st   = 1'($urandom);
            ia   = {$urandom, $urandom} & ~64'h3;
            la   = {$urandom, $urandom};
            wd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            fm   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            txn(u_if, cont, st, ia, la, wd, 8'($urandom), rd,
                $urandom_range(0, 3), $urandom_range(0, 3), fm);
            if ($urandom_range(0, 1) == 0) tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
